// File: rtl/pipe_fwd_scoreboard_if.sv
// Handshake/bus bundle between the ID stage and the hazard/forwarding unit.
// master: ID side (drives instruction fields, regfile data, stage results)
// slave : scoreboard (drives stall, resolved operands, forward flags)
interface pipe_fwd_scoreboard_if #(
    parameter int ADDR_W     = 5,
    parameter int DATA_W     = 32,
    parameter int FWD_STAGES = 3
);
    logic                         id_valid;
    logic                         id_flush;
    logic [ADDR_W-1:0]            id_rs;
    logic [ADDR_W-1:0]            id_rt;
    logic                         id_rs_used;
    logic                         id_rt_used;
    logic                         id_wen;
    logic [ADDR_W-1:0]            id_waddr;
    logic                         id_is_load;
    logic [DATA_W-1:0]            rf_rs_data;
    logic [DATA_W-1:0]            rf_rt_data;
    logic [DATA_W*FWD_STAGES-1:0] stage_data;
    logic                         stall;
    logic [DATA_W-1:0]            rs_data;
    logic [DATA_W-1:0]            rt_data;
    logic                         rs_fwd;
    logic                         rt_fwd;

    modport master (
        output id_valid, id_flush, id_rs, id_rt,
        output id_rs_used, id_rt_used, id_wen,
        output id_waddr, id_is_load,
        output rf_rs_data, rf_rt_data, stage_data,
        input  stall, rs_data, rt_data, rs_fwd, rt_fwd
    );

    modport slave (
        input  id_valid, id_flush, id_rs, id_rt,
        input  id_rs_used, id_rt_used, id_wen,
        input  id_waddr, id_is_load,
        input  rf_rs_data, rf_rt_data, stage_data,
        output stall, rs_data, rt_data, rs_fwd, rt_fwd
    );
endinterface

// File: rtl/pipe_fwd_scoreboard.sv
// Hazard/forwarding scoreboard: tracks destination tags of FWD_STAGES post-ID
// stages, resolves rs/rt operands and raises load-use stall.
// Ports: clk, cpu_rst_n (sync, active-low), cpu_en (advance), bus (slave).
// Optional HAZ_PERF_EN: perf_stall_cnt / perf_fwd_cnt event counters.
module pipe_fwd_scoreboard #(
    parameter int ADDR_W           = 5,
    parameter int DATA_W           = 32,
    parameter int FWD_STAGES       = 3,
    parameter int LOAD_READY_STAGE = 2
) (
    input logic               clk,
    input logic               cpu_rst_n,
    input logic               cpu_en,
    pipe_fwd_scoreboard_if.slave bus
`ifdef HAZ_PERF_EN
    ,
    output logic [31:0]       perf_stall_cnt,
    output logic [31:0]       perf_fwd_cnt
`endif
);

    logic [FWD_STAGES-1:0] r_v;
    logic [FWD_STAGES-1:0] r_ld;
    logic [ADDR_W-1:0]     r_waddr [FWD_STAGES];

    logic              w_rs_hit, w_rs_wait;
    logic              w_rt_hit, w_rt_wait;
    logic [DATA_W-1:0] w_rs_slice, w_rt_slice;
    logic              w_stall, w_issue, w_take;

    // Walk oldest to youngest so the youngest match overwrites.
    always_comb begin
        w_rs_hit   = 1'b0;
        w_rs_wait  = 1'b0;
        w_rs_slice = '0;
        w_rt_hit   = 1'b0;
        w_rt_wait  = 1'b0;
        w_rt_slice = '0;
        for (int k = FWD_STAGES - 1; k >= 0; k--) begin
            if (r_v[k] && bus.id_rs_used &&
                bus.id_rs != '0 && r_waddr[k] == bus.id_rs) begin
                w_rs_hit   = 1'b1;
                w_rs_wait  = r_ld[k] && (k < LOAD_READY_STAGE);
                w_rs_slice = bus.stage_data[k*DATA_W +: DATA_W];
            end
            if (r_v[k] && bus.id_rt_used &&
                bus.id_rt != '0 && r_waddr[k] == bus.id_rt) begin
                w_rt_hit   = 1'b1;
                w_rt_wait  = r_ld[k] && (k < LOAD_READY_STAGE);
                w_rt_slice = bus.stage_data[k*DATA_W +: DATA_W];
            end
        end
    end

    assign w_stall = (w_rs_wait | w_rt_wait) &
                     bus.id_valid & ~bus.id_flush;
    assign w_issue = bus.id_valid & ~bus.id_flush & ~w_stall;
    assign w_take  = w_issue & bus.id_wen & (bus.id_waddr != '0);

    assign bus.stall   = w_stall;
    assign bus.rs_fwd  = w_rs_hit & ~w_rs_wait;
    assign bus.rt_fwd  = w_rt_hit & ~w_rt_wait;
    assign bus.rs_data = bus.rs_fwd ? w_rs_slice : bus.rf_rs_data;
    assign bus.rt_data = bus.rt_fwd ? w_rt_slice : bus.rf_rt_data;

    always_ff @(posedge clk) begin
        if (!cpu_rst_n) begin
            r_v  <= '0;
            r_ld <= '0;
            for (int k = 0; k < FWD_STAGES; k++) r_waddr[k] <= '0;
        end else if (cpu_en) begin
            for (int k = 1; k < FWD_STAGES; k++) begin
                r_v[k]     <= r_v[k-1];
                r_ld[k]    <= r_ld[k-1];
                r_waddr[k] <= r_waddr[k-1];
            end
            r_v[0]     <= w_take;
            r_ld[0]    <= w_take & bus.id_is_load;
            r_waddr[0] <= w_take ? bus.id_waddr : '0;
        end
    end

`ifdef HAZ_PERF_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_fwd_cnt;

    always_ff @(posedge clk) begin
        if (!cpu_rst_n) begin
            r_stall_cnt <= '0;
            r_fwd_cnt   <= '0;
        end else if (cpu_en) begin
            if (w_stall)
                r_stall_cnt <= r_stall_cnt + 32'd1;
            else if (bus.rs_fwd | bus.rt_fwd)
                r_fwd_cnt <= r_fwd_cnt + 32'd1;
        end
    end

    assign perf_stall_cnt = r_stall_cnt;
    assign perf_fwd_cnt   = r_fwd_cnt;
`endif

endmodule
